// File: rtl/semaforo_pkg.sv
// Shared lamp codes and FSM state encodings for the semaforo traffic-light family.
package semaforo_pkg;

  localparam logic [2:0] LT_RED = 3'b001;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b100;
  localparam logic [2:0] LT_OFF = 3'b000;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_FLASH  = 2'd3
  } state_e;

endpackage

// File: rtl/semaforo_rr_pick.sv
// Combinational round-robin pick over side ways 1..N_WAYS-1, starting after last_side_i.
module semaforo_rr_pick #(
  parameter int unsigned N_WAYS = 3,
  parameter int unsigned AW     = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] pending_i,
  input  logic [AW-1:0]     last_side_i,
  output logic [AW-1:0]     next_o,
  output logic              valid_o
);

  always_comb begin
    int unsigned cand;
    cand    = 0;
    next_o  = '0;
    valid_o = 1'b0;
    for (int unsigned k = 1; k < N_WAYS; k++) begin
      // Side ways form a ring of N_WAYS-1 slots; way 0 is never a candidate.
      cand = ((32'(last_side_i) + k - 1) % (N_WAYS - 1)) + 1;
      if (!valid_o && pending_i[cand]) begin
        valid_o = 1'b1;
        next_o  = AW'(cand);
      end
    end
  end

endmodule

// File: rtl/semaforo_multi.sv
// N-way traffic-light controller: main road rests green, side ways served round-robin.
// Optional night flashing mode enabled by defining SEMAFORO_NIGHT_EN.
module semaforo_multi
  import semaforo_pkg::*;
#(
  parameter int unsigned N_WAYS    = 3,
  parameter int unsigned GREEN_T   = 8,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned RED_CLR_T = 2,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned AW        = $clog2(N_WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_WAYS-1:0]     req,
  output logic [3*N_WAYS-1:0]   lights,
  output logic [AW-1:0]         active,
  output logic [N_WAYS-1:0]     pending
`ifdef SEMAFORO_NIGHT_EN
  ,
  input  logic                  night
`endif
);

  localparam logic [CNT_W-1:0] GreenLast = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YelLast   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] RedLast   = CNT_W'(RED_CLR_T - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [AW-1:0]         active_q, active_d;
  logic [AW-1:0]         last_side_q, last_side_d;
  logic [N_WAYS-1:0]     pending_q, pending_d;
  logic [3*N_WAYS-1:0]   lights_q, lights_d;
  // Forces the next ALLRED exit to way 0 (after reset or after leaving FLASH).
  logic                  main_next_q, main_next_d;
  logic [AW-1:0]         pick_idx;
  logic                  pick_valid;
  logic                  green_entry;
`ifdef SEMAFORO_NIGHT_EN
  logic                  flash_on_q, flash_on_d;
`endif

  semaforo_rr_pick #(
    .N_WAYS (N_WAYS),
    .AW     (AW)
  ) u_rr_pick (
    .pending_i   (pending_q),
    .last_side_i (last_side_q),
    .next_o      (pick_idx),
    .valid_o     (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q + 1'b1;
    active_d    = active_q;
    last_side_d = last_side_q;
    main_next_d = main_next_q;
`ifdef SEMAFORO_NIGHT_EN
    flash_on_d  = flash_on_q;
`endif
    unique case (state_q)
      S_GREEN: begin
        if (count_q == GreenLast) begin
          if (active_q != '0 || pending_q != '0) begin
            state_d = S_YELLOW;
            count_d = '0;
          end else begin
            // Main road holds; saturate so the minimum-green test stays true.
            count_d = count_q;
          end
        end
      end
      S_YELLOW: begin
        if (count_q == YelLast) begin
          state_d = S_ALLRED;
          count_d = '0;
        end
      end
      S_ALLRED: begin
        if (count_q == RedLast) begin
          count_d = '0;
`ifdef SEMAFORO_NIGHT_EN
          if (night) begin
            state_d    = S_FLASH;
            flash_on_d = 1'b1;
          end else
`endif
          begin
            state_d     = S_GREEN;
            main_next_d = 1'b0;
            if (main_next_q || active_q != '0 || !pick_valid) begin
              active_d = '0;
            end else begin
              active_d    = pick_idx;
              last_side_d = pick_idx;
            end
          end
        end
      end
`ifdef SEMAFORO_NIGHT_EN
      S_FLASH: begin
        if (!night) begin
          state_d     = S_ALLRED;
          count_d     = '0;
          main_next_d = 1'b1;
        end else if (count_q == RedLast) begin
          count_d    = '0;
          flash_on_d = ~flash_on_q;
        end
      end
`endif
      default: begin
        state_d = S_ALLRED;
        count_d = '0;
      end
    endcase

    green_entry = (state_d == S_GREEN) && (state_q != S_GREEN);
    pending_d   = '0;
    for (int i = 1; i < N_WAYS; i++) begin
      pending_d[i] = pending_q[i] |
                     (req[i] & ~((state_q == S_GREEN) && (active_q == AW'(i))));
      if (green_entry && active_d == AW'(i)) begin
        pending_d[i] = 1'b0;
      end
    end

    lights_d = {N_WAYS{LT_RED}};
    for (int i = 0; i < N_WAYS; i++) begin
      if (active_d == AW'(i)) begin
        if (state_d == S_GREEN) begin
          lights_d[3*i +: 3] = LT_GRN;
        end else if (state_d == S_YELLOW) begin
          lights_d[3*i +: 3] = LT_YEL;
        end
      end
`ifdef SEMAFORO_NIGHT_EN
      if (state_d == S_FLASH) begin
        lights_d[3*i +: 3] = flash_on_d ? LT_YEL : LT_OFF;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_ALLRED;
      count_q     <= '0;
      active_q    <= '0;
      last_side_q <= '0;
      pending_q   <= '0;
      lights_q    <= {N_WAYS{LT_RED}};
      main_next_q <= 1'b1;
`ifdef SEMAFORO_NIGHT_EN
      flash_on_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      active_q    <= active_d;
      last_side_q <= last_side_d;
      pending_q   <= pending_d;
      lights_q    <= lights_d;
      main_next_q <= main_next_d;
`ifdef SEMAFORO_NIGHT_EN
      flash_on_q  <= flash_on_d;
`endif
    end
  end

  assign lights  = lights_q;
  assign active  = active_q;
  assign pending = pending_q;

endmodule
